// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg : per-axis timing mode record and standard mode constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33}
  };

  localparam vga_mode_t MODE_800x600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
  };

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line : DEPTH-stage shift register, async clear to INIT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_w;
    assign unused_w = clk ^ rst_n ^ (|INIT);
    assign data_o   = data_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= INIT;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen : parametrised VGA sync/DE/request generator, latency aligned
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = int'(MODE_640x480_60.h.active),
  parameter int H_FP     = int'(MODE_640x480_60.h.fp),
  parameter int H_SYNC   = int'(MODE_640x480_60.h.sync),
  parameter int H_BP     = int'(MODE_640x480_60.h.bp),
  parameter int V_ACTIVE = int'(MODE_640x480_60.v.active),
  parameter int V_FP     = int'(MODE_640x480_60.v.fp),
  parameter int V_SYNC   = int'(MODE_640x480_60.v.sync),
  parameter int V_BP     = int'(MODE_640x480_60.v.bp),
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = 12,
  parameter int PIX_LAT  = 1
) (
  input  logic               clk_25m,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] pixel_r,
  input  logic [COLOR_W-1:0] pixel_g,
  input  logic [COLOR_W-1:0] pixel_b,
  output logic               req_valid,
  output logic [CNT_W-1:0]   req_x,
  output logic [CNT_W-1:0]   req_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hsy,
  output logic               vga_vsy,
  output logic               vga_de
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic             HS_ON     = (H_POL != 0);
  localparam logic             VS_ON     = (V_POL != 0);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: every horizontal timing parameter must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: every vertical timing parameter must be >= 1");
  end
  if (H_TOT >= (1 << CNT_W) || V_TOT >= (1 << CNT_W)) begin : g_bad_w
    $error("vga_timing_gen: H/V totals do not fit in CNT_W bits");
  end
  if (PIX_LAT < 0 || PIX_LAT > 15) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be within 0..15");
  end

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] req_x_q, req_x_d, req_y_q, req_y_d;
  logic             req_valid_q, req_valid_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             hs_q, hs_d, vs_q, vs_d;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // Request stage decodes the position the counters hold during this cycle.
  always_comb begin
    req_valid_d   = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                    (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    req_x_d       = req_valid_d ? (h_cnt_q - H_ACT_BEG) : req_x_q;
    req_y_d       = req_valid_d ? (v_cnt_q - V_ACT_BEG) : req_y_q;
    line_start_d  = req_valid_d && (h_cnt_q == H_ACT_BEG);
    frame_start_d = line_start_d && (v_cnt_q == V_ACT_BEG);
    hs_d          = (h_cnt_q < H_SYN_END);
    vs_d          = (v_cnt_q < V_SYN_END);
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      req_valid_q   <= req_valid_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  // Controls wait PIX_LAT cycles so they meet the pixel data they belong to.
  logic [2:0] dly_out;
  logic       dly_act, dly_hs, dly_vs;

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LAT),
    .INIT  (3'b000)
  ) u_ctrl_dly (
    .clk    (clk_25m),
    .rst_n  (rst_n),
    .data_i ({req_valid_q, hs_q, vs_q}),
    .data_o (dly_out)
  );

  assign {dly_act, dly_hs, dly_vs} = dly_out;

  logic               de_q, hsy_q, vsy_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hsy_q <= ~HS_ON;
      vsy_q <= ~VS_ON;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      de_q  <= dly_act;
      hsy_q <= dly_hs ? HS_ON : ~HS_ON;
      vsy_q <= dly_vs ? VS_ON : ~VS_ON;
      r_q   <= dly_act ? pixel_r : '0;
      g_q   <= dly_act ? pixel_g : '0;
      b_q   <= dly_act ? pixel_b : '0;
    end
  end

  assign vga_de  = de_q;
  assign vga_hsy = hsy_q;
  assign vga_vsy = vsy_q;
  assign vga_r   = r_q;
  assign vga_g   = g_q;
  assign vga_b   = b_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen : scoreboard bench over a small mode, four latency/polarity variants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  localparam int HA = 10, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 2;
  localparam int H_TOT = HS + HB + HA + HF;
  localparam int V_TOT = VS + VB + VA + VF;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int FIRST_REQ = (VS + VB) * H_TOT + HS + HB;
  localparam int NDUT = 4;

  typedef struct packed {
    logic       act;
    logic [7:0] x;
    logic [7:0] y;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 15;
      default: return 3;
    endcase
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int   L     = lat_of(gi);
    localparam int   POL   = (gi == 1) ? 0 : 1;
    localparam logic POL_B = (POL != 0);

    logic       rv, ls, fs, de, hsy, vsy;
    logic [7:0] rx, ry;
    logic [0:0] pr, pg, pb, vr, vg, vb;

    vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .H_POL (POL), .V_POL (POL), .COLOR_W (1), .CNT_W (8), .PIX_LAT (L)
    ) u_dut (
      .clk_25m     (clk),
      .rst_n       (rst_n),
      .pixel_r     (pr),
      .pixel_g     (pg),
      .pixel_b     (pb),
      .req_valid   (rv),
      .req_x       (rx),
      .req_y       (ry),
      .line_start  (ls),
      .frame_start (fs),
      .vga_r       (vr),
      .vga_g       (vg),
      .vga_b       (vb),
      .vga_hsy     (hsy),
      .vga_vsy     (vsy),
      .vga_de      (de)
    );

    // Pixel source: colour derived from the request coordinates, L cycles late.
    if (L == 0) begin : g_pix_comb
      assign pr = rx[0];
      assign pg = rx[1];
      assign pb = ry[0];
    end else begin : g_pix_pipe
      logic [7:0] hx [L];
      logic [7:0] hy [L];
      always @(posedge clk) begin
        hx[0] <= rx;
        hy[0] <= ry;
        for (int k = 1; k < L; k++) begin
          hx[k] <= hx[k-1];
          hy[k] <= hy[k-1];
        end
      end
      assign pr = hx[L-1][0];
      assign pg = hx[L-1][1];
      assign pb = hy[L-1][0];
    end

    // rst_n only changes 2 time units after a posedge, so the level seen at the
    // previous negedge is the level the DUT saw at the posedge in between.
    initial begin : p_chk
      exp_t       q[$];
      exp_t       b, er, eo;
      int         mh, mv, cyc, rv_t;
      logic [7:0] lx, ly;
      logic       prev_rst, prv, pde;
      mh = 0; mv = 0; cyc = 0; rv_t = 0;
      lx = '0; ly = '0; prev_rst = 1'b0; prv = 1'b0; pde = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          q.delete();
          mh = 0; mv = 0; lx = '0; ly = '0;
        end else if (prev_rst) begin
          b.hs  = (mh < HS);
          b.vs  = (mv < VS);
          b.act = (mh >= HS + HB) && (mh < HS + HB + HA) &&
                  (mv >= VS + VB) && (mv < VS + VB + VA);
          if (b.act) begin
            lx = 8'(mh - (HS + HB));
            ly = 8'(mv - (VS + VB));
          end
          b.x  = lx;
          b.y  = ly;
          b.ls = b.act && (mh == HS + HB);
          b.fs = b.ls && (mv == VS + VB);
          q.push_back(b);
          mh++;
          if (mh == H_TOT) begin
            mh = 0;
            mv++;
            if (mv == V_TOT) mv = 0;
          end
        end
        prev_rst = rst_n;
        er = (q.size() > 0) ? q[$] : '0;
        eo = '0;
        if (q.size() > L + 1) eo = q.pop_front();

        check_val($sformatf("dut%0d.req_valid", gi), int'(rv), int'(er.act));
        check_val($sformatf("dut%0d.req_x", gi), int'(rx), int'(er.x));
        check_val($sformatf("dut%0d.req_y", gi), int'(ry), int'(er.y));
        check_val($sformatf("dut%0d.line_start", gi), int'(ls), int'(er.ls));
        check_val($sformatf("dut%0d.frame_start", gi), int'(fs), int'(er.fs));
        check_val($sformatf("dut%0d.vga_de", gi), int'(de), int'(eo.act));
        check_val($sformatf("dut%0d.vga_hsy", gi), int'(hsy), int'(eo.hs ? POL_B : !POL_B));
        check_val($sformatf("dut%0d.vga_vsy", gi), int'(vsy), int'(eo.vs ? POL_B : !POL_B));
        check_val($sformatf("dut%0d.vga_r", gi), int'(vr), int'(eo.act ? eo.x[0] : 1'b0));
        check_val($sformatf("dut%0d.vga_g", gi), int'(vg), int'(eo.act ? eo.x[1] : 1'b0));
        check_val($sformatf("dut%0d.vga_b", gi), int'(vb), int'(eo.act ? eo.y[0] : 1'b0));

        if (rv && !prv) rv_t = cyc;
        if (de && !pde) check_val($sformatf("dut%0d.de_lag", gi), cyc - rv_t, L + 1);
        prv = rv;
        pde = de;
      end
    end
  end

  initial begin : p_main
    int n, vlo, hlo, nls, nfs, nde;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst.hsy_pol1", int'(g_dut[0].hsy), 0);
    check_val("rst.hsy_pol0", int'(g_dut[1].hsy), 1);
    check_val("rst.vsy_pol0", int'(g_dut[1].vsy), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end while (!g_dut[0].rv && n < 400);
    check_val("first_req_lag", n, FIRST_REQ + 2);
    check_val("first_req_is_frame_start", int'(g_dut[0].fs), 1);

    n = 0;
    do begin @(negedge clk); n++; end while (!g_dut[0].fs && n < 400);
    check_val("frame_period", n, FRAME);

    vlo = 0; hlo = 0; nls = 0; nfs = 0; nde = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (!g_dut[1].vsy) vlo++;
      if (!g_dut[1].hsy) hlo++;
      if (g_dut[0].ls) nls++;
      if (g_dut[0].fs) nfs++;
      if (g_dut[2].de) nde++;
    end
    check_val("vsy_low_per_frame", vlo, VS * H_TOT);
    check_val("hsy_low_per_frame", hlo, HS * V_TOT);
    check_val("line_starts_per_frame", nls, VA);
    check_val("frame_starts_per_frame", nfs, 1);
    check_val("de_cycles_per_frame", nde, HA * VA);

    n = 0;
    while (!(g_dut[0].rv && g_dut[0].ry == 8'd2 && g_dut[0].rx == 8'd4) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("midframe_point_reached", int'(n < 400), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("midrst.req_valid", int'(g_dut[0].rv), 0);
      check_val("midrst.de", int'(g_dut[2].de), 0);
      check_val("midrst.hsy_pol1", int'(g_dut[3].hsy), 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end while (!g_dut[0].rv && n < 400);
    check_val("restart_first_req_lag", n, FIRST_REQ + 2);

    repeat (FRAME + 40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
